// File: rtl/lsu_pkg.sv
// Shared definitions for the load/store unit: op codes, FSM states, word width
// and the alignment rule applied when a request is accepted.
package lsu_pkg;

   localparam int WORD_W = 32;

   typedef enum logic [2:0] {
      OP_LW  = 3'd0,
      OP_LH  = 3'd1,
      OP_LHU = 3'd2,
      OP_LB  = 3'd3,
      OP_LBU = 3'd4,
      OP_SW  = 3'd5,
      OP_SH  = 3'd6,
      OP_SB  = 3'd7
   } op_e;

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_RD   = 2'd1,
      ST_WR   = 2'd2,
      ST_RESP = 2'd3
   } state_e;

   // Word accesses need a 4-byte boundary, halfwords a 2-byte one, bytes none.
   function automatic logic is_misaligned(op_e op, logic [1:0] addr_lo);
      case (op)
         OP_LB, OP_LBU, OP_SB: return 1'b0;
         OP_LH, OP_LHU, OP_SH: return addr_lo[0];
         default:              return addr_lo != 2'b00;
      endcase
   endfunction

   function automatic logic is_subword_store(op_e op);
      return (op == OP_SH) || (op == OP_SB);
   endfunction

endpackage

// File: rtl/lsu_if.sv
// CPU request/response and memory-port bundle of the load/store unit.
// slave is the LSU view; master is the CPU-plus-memory environment view.
interface lsu_if;
   import lsu_pkg::*;

   logic              req_valid;
   logic              req_ready;
   logic [2:0]        req_op;
   logic [WORD_W-1:0] req_addr;
   logic [WORD_W-1:0] req_wdata;
   logic [WORD_W-1:0] req_pc;
   logic              resp_valid;
   logic [WORD_W-1:0] resp_rdata;
   logic              resp_err;
   logic [WORD_W-1:0] mem_addr;
   logic [WORD_W-1:0] mem_wdata;
   logic              mem_we;
   logic              mem_re;
   logic [WORD_W-1:0] mem_rdata;
   logic [WORD_W-1:0] mem_pc;

   modport slave (
      input  req_valid, req_op, req_addr, req_wdata, req_pc, mem_rdata,
      output req_ready, resp_valid, resp_rdata, resp_err,
             mem_addr, mem_wdata, mem_we, mem_re, mem_pc
   );

   modport master (
      output req_valid, req_op, req_addr, req_wdata, req_pc, mem_rdata,
      input  req_ready, resp_valid, resp_rdata, resp_err,
             mem_addr, mem_wdata, mem_we, mem_re, mem_pc
   );

endinterface

// File: rtl/lsu_align.sv
// Combinational byte-lane logic: load extract with sign/zero extension and
// store merge of a byte/halfword into the previously read word.
module lsu_align
   import lsu_pkg::*;
(
   input  op_e               op,
   input  logic [1:0]        addr_lo,
   input  logic [WORD_W-1:0] rdata,
   input  logic [WORD_W-1:0] wdata,
   output logic [WORD_W-1:0] load_data,
   output logic [WORD_W-1:0] store_word
);

   logic [7:0]  lane_b;
   logic [15:0] lane_h;

   always_comb begin
      lane_b = rdata[{addr_lo, 3'b000} +: 8];
      lane_h = addr_lo[1] ? rdata[31:16] : rdata[15:0];

      case (op)
         OP_LB:   load_data = {{24{lane_b[7]}}, lane_b};
         OP_LBU:  load_data = {24'd0, lane_b};
         OP_LH:   load_data = {{16{lane_h[15]}}, lane_h};
         OP_LHU:  load_data = {16'd0, lane_h};
         default: load_data = rdata;
      endcase

      // Untouched lanes keep the old memory contents.
      store_word = rdata;
      case (op)
         OP_SB: store_word[{addr_lo, 3'b000} +: 8] = wdata[7:0];
         OP_SH: begin
            if (addr_lo[1]) store_word[31:16] = wdata[15:0];
            else            store_word[15:0]  = wdata[15:0];
         end
         default: store_word = wdata;
      endcase
   end

endmodule

// File: rtl/lsu.sv
// Load/store unit: single-outstanding FSM with read-modify-write for
// sub-word stores; all outputs come straight from flops.
module lsu
   import lsu_pkg::*;
(
   input  logic clk,
   input  logic reset,
   lsu_if.slave bus
);

   state_e            state_q,      state_d;
   op_e               op_q,         op_d;
   logic [1:0]        addr_lo_q,    addr_lo_d;
   logic [WORD_W-1:0] wdata_q,      wdata_d;
   logic              req_ready_q,  req_ready_d;
   logic              resp_valid_q, resp_valid_d;
   logic              resp_err_q,   resp_err_d;
   logic [WORD_W-1:0] resp_rdata_q, resp_rdata_d;
   logic [WORD_W-1:0] mem_addr_q,   mem_addr_d;
   logic [WORD_W-1:0] mem_wdata_q,  mem_wdata_d;
   logic              mem_we_q,     mem_we_d;
   logic              mem_re_q,     mem_re_d;
   logic [WORD_W-1:0] mem_pc_q,     mem_pc_d;

   op_e               req_op_e;
   logic [WORD_W-1:0] load_data;
   logic [WORD_W-1:0] store_word;

   assign req_op_e = op_e'(bus.req_op);

   lsu_align u_align (
      .op         (op_q),
      .addr_lo    (addr_lo_q),
      .rdata      (bus.mem_rdata),
      .wdata      (wdata_q),
      .load_data  (load_data),
      .store_word (store_word)
   );

   always_comb begin
      state_d      = state_q;
      op_d         = op_q;
      addr_lo_d    = addr_lo_q;
      wdata_d      = wdata_q;
      req_ready_d  = req_ready_q;
      resp_valid_d = 1'b0;
      resp_err_d   = resp_err_q;
      resp_rdata_d = resp_rdata_q;
      mem_addr_d   = mem_addr_q;
      mem_wdata_d  = mem_wdata_q;
      mem_we_d     = 1'b0;
      mem_re_d     = 1'b0;
      mem_pc_d     = mem_pc_q;

      case (state_q)
         ST_IDLE: begin
            if (bus.req_valid) begin
               op_d        = req_op_e;
               addr_lo_d   = bus.req_addr[1:0];
               wdata_d     = bus.req_wdata;
               mem_addr_d  = {bus.req_addr[WORD_W-1:2], 2'b00};
               mem_pc_d    = bus.req_pc;
               req_ready_d = 1'b0;
               if (is_misaligned(req_op_e, bus.req_addr[1:0])) begin
                  state_d      = ST_RESP;
                  resp_valid_d = 1'b1;
                  resp_err_d   = 1'b1;
                  resp_rdata_d = '0;
               end else if (req_op_e == OP_SW) begin
                  state_d     = ST_WR;
                  mem_we_d    = 1'b1;
                  mem_wdata_d = bus.req_wdata;
               end else begin
                  state_d  = ST_RD;
                  mem_re_d = 1'b1;
               end
            end
         end
         // mem_rdata is valid during RD; it either completes a load or seeds the merge.
         ST_RD: begin
            if (is_subword_store(op_q)) begin
               state_d     = ST_WR;
               mem_we_d    = 1'b1;
               mem_wdata_d = store_word;
            end else begin
               state_d      = ST_RESP;
               resp_valid_d = 1'b1;
               resp_err_d   = 1'b0;
               resp_rdata_d = load_data;
            end
         end
         ST_WR: begin
            state_d      = ST_RESP;
            resp_valid_d = 1'b1;
            resp_err_d   = 1'b0;
            resp_rdata_d = '0;
         end
         default: begin
            state_d      = ST_IDLE;
            req_ready_d  = 1'b1;
            resp_err_d   = 1'b0;
            resp_rdata_d = '0;
         end
      endcase
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state_q      <= ST_IDLE;
         op_q         <= OP_LW;
         addr_lo_q    <= '0;
         wdata_q      <= '0;
         req_ready_q  <= 1'b1;
         resp_valid_q <= 1'b0;
         resp_err_q   <= 1'b0;
         resp_rdata_q <= '0;
         mem_addr_q   <= '0;
         mem_wdata_q  <= '0;
         mem_we_q     <= 1'b0;
         mem_re_q     <= 1'b0;
         mem_pc_q     <= '0;
      end else begin
         state_q      <= state_d;
         op_q         <= op_d;
         addr_lo_q    <= addr_lo_d;
         wdata_q      <= wdata_d;
         req_ready_q  <= req_ready_d;
         resp_valid_q <= resp_valid_d;
         resp_err_q   <= resp_err_d;
         resp_rdata_q <= resp_rdata_d;
         mem_addr_q   <= mem_addr_d;
         mem_wdata_q  <= mem_wdata_d;
         mem_we_q     <= mem_we_d;
         mem_re_q     <= mem_re_d;
         mem_pc_q     <= mem_pc_d;
      end
   end

   assign bus.req_ready  = req_ready_q;
   assign bus.resp_valid = resp_valid_q;
   assign bus.resp_err   = resp_err_q;
   assign bus.resp_rdata = resp_rdata_q;
   assign bus.mem_addr   = mem_addr_q;
   assign bus.mem_wdata  = mem_wdata_q;
   assign bus.mem_we     = mem_we_q;
   assign bus.mem_re     = mem_re_q;
   assign bus.mem_pc     = mem_pc_q;

endmodule

// File: tb/tb_lsu.sv
// Scoreboard bench for lsu: directed requests push expected responses, a
// negedge monitor pops and compares data, error flag and latency.
module tb_lsu;
   import lsu_pkg::*;

   typedef struct {
      logic [31:0] rdata;
      logic        err;
      int          cyc0;
      int          lat;
   } exp_t;

   logic clk;
   logic reset_n;
   int   cyc;
   int   n_checks;
   int   n_fail;
   int   we_cnt;
   int   re_cnt;
   int   resp_cnt;
   logic [31:0] last_waddr;
   logic [31:0] last_wdata;
   logic [31:0] last_wpc;
   logic [31:0] mem [0:63];
   exp_t sb_q[$];

   lsu_if bus ();

   lsu dut (
      .clk   (clk),
      .reset (reset_n),
      .bus   (bus)
   );

   assign bus.mem_rdata = mem[bus.mem_addr[7:2]];

   initial clk = 1'b0;
   always #5 clk = ~clk;

   always @(posedge clk) begin
      cyc <= cyc + 1;
      if (bus.mem_we) mem[bus.mem_addr[7:2]] <= bus.mem_wdata;
   end

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %h expected %h", name, act, exp);
      end
   endtask

   task automatic fail_now(input string name);
      n_checks++;
      n_fail++;
      $display("FAIL %s: event not seen within bound", name);
   endtask

   // Monitor: responses, write-port activity and port exclusivity.
   always @(negedge clk) begin
      if (reset_n) begin
         check("we_re_excl", {31'd0, bus.mem_we & bus.mem_re}, 32'd0);
         if (bus.req_ready || bus.resp_valid)
            check("mem_idle_resp", {31'd0, bus.mem_we | bus.mem_re}, 32'd0);
         if (bus.mem_we) begin
            we_cnt++;
            last_waddr = bus.mem_addr;
            last_wdata = bus.mem_wdata;
            last_wpc   = bus.mem_pc;
         end
         if (bus.mem_re) re_cnt++;
         if (bus.resp_valid) begin
            resp_cnt++;
            if (sb_q.size() == 0) begin
               fail_now("unexpected_resp");
            end else begin
               exp_t e;
               e = sb_q.pop_front();
               check("resp_rdata", bus.resp_rdata, e.rdata);
               check("resp_err", {31'd0, bus.resp_err}, {31'd0, e.err});
               check("resp_latency", cyc - e.cyc0, e.lat);
            end
         end
      end
   end

   task automatic do_op(input op_e op, input logic [31:0] addr, input logic [31:0] wdata,
                        input logic [31:0] pc, input logic [31:0] exp_rdata,
                        input logic exp_err, input int exp_lat);
      int waitc;
      @(negedge clk);
      bus.req_valid = 1'b1;
      bus.req_op    = op;
      bus.req_addr  = addr;
      bus.req_wdata = wdata;
      bus.req_pc    = pc;
      waitc = 0;
      while (!bus.req_ready && waitc < 20) begin
         @(negedge clk);
         waitc++;
      end
      if (!bus.req_ready) begin
         fail_now("accept_timeout");
         bus.req_valid = 1'b0;
         return;
      end
      sb_q.push_back('{exp_rdata, exp_err, cyc, exp_lat});
      @(negedge clk);
      bus.req_valid = 1'b0;
      waitc = 0;
      while ((sb_q.size() != 0 || !bus.req_ready) && waitc < 20) begin
         @(negedge clk);
         waitc++;
      end
      if (sb_q.size() != 0) begin
         fail_now("resp_timeout");
         sb_q.delete();
      end
   endtask

   initial begin
      #200000;
      $display("FAIL global_timeout: simulation did not finish");
      $fatal(1, "timeout");
   end

   initial begin
      int we0;
      int re0;
      int r0;
      int lowc;
      int waitc;
      cyc = 0; n_checks = 0; n_fail = 0;
      we_cnt = 0; re_cnt = 0; resp_cnt = 0;
      last_waddr = '0; last_wdata = '0; last_wpc = '0;
      for (int i = 0; i < 64; i++) mem[i] = 32'h0;
      mem[4] = 32'h8899AABB;
      bus.req_valid = 1'b0; bus.req_op = 3'd0;
      bus.req_addr = '0; bus.req_wdata = '0; bus.req_pc = '0;
      reset_n = 1'b1;
      #2 reset_n = 1'b0;
      #1;
      check("rst_req_ready", {31'd0, bus.req_ready}, 32'd1);
      check("rst_resp_valid", {31'd0, bus.resp_valid}, 32'd0);
      check("rst_resp_err", {31'd0, bus.resp_err}, 32'd0);
      check("rst_resp_rdata", bus.resp_rdata, 32'd0);
      check("rst_mem_we_re", {30'd0, bus.mem_we, bus.mem_re}, 32'd0);
      check("rst_mem_addr", bus.mem_addr, 32'd0);
      check("rst_mem_wdata", bus.mem_wdata, 32'd0);
      check("rst_mem_pc", bus.mem_pc, 32'd0);
      repeat (2) @(negedge clk);
      reset_n = 1'b1;

      we0 = we_cnt;
      do_op(OP_LB, 32'h11, 32'h0, 32'h100, 32'hFFFFFFAA, 1'b0, 2);
      check("lb_no_we", we_cnt - we0, 0);

      we0 = we_cnt;
      do_op(OP_SB, 32'h12, 32'h55, 32'h104, 32'h0, 1'b0, 3);
      check("sb_we_once", we_cnt - we0, 1);
      check("sb_wdata", last_wdata, 32'h8855AABB);
      check("sb_mem", mem[4], 32'h8855AABB);
      do_op(OP_LW, 32'h10, 32'h0, 32'h108, 32'h8855AABB, 1'b0, 2);

      we0 = we_cnt; re0 = re_cnt;
      do_op(OP_LH, 32'h13, 32'h0, 32'h10C, 32'h0, 1'b1, 1);
      check("lh_mis_no_we", we_cnt - we0, 0);
      check("lh_mis_no_re", re_cnt - re0, 0);

      do_op(OP_LB,  32'h13, 32'h0, 32'h110, 32'hFFFFFF88, 1'b0, 2);
      do_op(OP_LBU, 32'h13, 32'h0, 32'h114, 32'h00000088, 1'b0, 2);
      do_op(OP_LH,  32'h12, 32'h0, 32'h118, 32'hFFFF8855, 1'b0, 2);
      do_op(OP_LHU, 32'h10, 32'h0, 32'h11C, 32'h0000AABB, 1'b0, 2);
      do_op(OP_LW,  32'h12, 32'h0, 32'h120, 32'h0, 1'b1, 1);
      we0 = we_cnt;
      do_op(OP_SW,  32'h21, 32'hDEADBEEF, 32'h124, 32'h0, 1'b1, 1);
      check("sw_mis_no_we", we_cnt - we0, 0);

      we0 = we_cnt;
      do_op(OP_SW, 32'h20, 32'h12345678, 32'h00003000, 32'h0, 1'b0, 2);
      check("sw_we_once", we_cnt - we0, 1);
      check("sw_addr", last_waddr, 32'h20);
      check("sw_pc", last_wpc, 32'h00003000);
      check("sw_mem", mem[8], 32'h12345678);
      do_op(OP_LHU, 32'h22, 32'h0, 32'h128, 32'h00001234, 1'b0, 2);
      do_op(OP_LH,  32'h20, 32'h0, 32'h12C, 32'h00005678, 1'b0, 2);
      do_op(OP_SH,  32'h22, 32'h0000BEEF, 32'h130, 32'h0, 1'b0, 3);
      check("sh_mem", mem[8], 32'hBEEF5678);
      do_op(OP_LH,  32'h22, 32'h0, 32'h134, 32'hFFFFBEEF, 1'b0, 2);

      // Abort an SH in its write cycle with reset.
      @(negedge clk);
      check("abort_ready", {31'd0, bus.req_ready}, 32'd1);
      bus.req_valid = 1'b1; bus.req_op = OP_SH;
      bus.req_addr = 32'h20; bus.req_wdata = 32'h0000CAFE; bus.req_pc = 32'h200;
      @(negedge clk);
      bus.req_valid = 1'b0;
      waitc = 0;
      while (!bus.mem_we && waitc < 5) begin
         @(negedge clk);
         waitc++;
      end
      if (!bus.mem_we) fail_now("abort_wr_phase");
      r0 = resp_cnt;
      reset_n = 1'b0;
      #1;
      check("abort_we_low", {31'd0, bus.mem_we}, 32'd0);
      check("abort_re_low", {31'd0, bus.mem_re}, 32'd0);
      check("abort_ready_hi", {31'd0, bus.req_ready}, 32'd1);
      check("abort_resp_valid", {31'd0, bus.resp_valid}, 32'd0);
      check("abort_mem_addr", bus.mem_addr, 32'd0);
      check("abort_mem_wdata", bus.mem_wdata, 32'd0);
      check("abort_mem_pc", bus.mem_pc, 32'd0);
      @(posedge clk);
      #1;
      check("abort_mem_unchanged", mem[8], 32'hBEEF5678);
      @(negedge clk);
      reset_n = 1'b1;
      repeat (4) @(negedge clk);
      check("abort_no_resp", resp_cnt - r0, 0);
      do_op(OP_LW, 32'h20, 32'h0, 32'h204, 32'hBEEF5678, 1'b0, 2);

      // Back-to-back loads with req_valid held high.
      @(negedge clk);
      bus.req_valid = 1'b1; bus.req_op = OP_LW;
      bus.req_addr = 32'h10; bus.req_wdata = '0; bus.req_pc = 32'h300;
      for (int k = 0; k < 2; k++) begin
         check("b2b_ready_at_issue", {31'd0, bus.req_ready}, 32'd1);
         sb_q.push_back('{32'h8855AABB, 1'b0, cyc, 2});
         @(negedge clk);
         lowc = 0;
         while (!bus.req_ready && lowc < 10) begin
            lowc++;
            @(negedge clk);
         end
         check("b2b_ready_low_cycles", lowc, 2);
      end
      bus.req_valid = 1'b0;
      repeat (3) @(negedge clk);
      check("sb_drained", sb_q.size(), 0);

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
